// File: rtl/peri_timer_pkg.sv
// Shared constants for the timer peripheral: bridge address map, default widths and divider.
package peri_timer_pkg;

    localparam int unsigned TIMER_CNT_W        = 32;
    localparam int unsigned TIMER_DIV_W        = 32;
    localparam logic [31:0] TIMER_DEFAULT_DIV  = 32'd25000;  // 1 ms tick at 25 MHz

    localparam logic [31:0] PERI_ADDR_TIMER_WR = 32'h4000_0000;
    localparam logic [31:0] PERI_ADDR_TIMER_W  = 32'h4000_0004;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable clock prescaler: counts 0..div-1 and flags the terminal count combinationally.
module timer_prescaler
    import peri_timer_pkg::*;
#(
    parameter int unsigned DIV_W = TIMER_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_clr,
    output logic             o_pulse
);

    logic [DIV_W-1:0] r_pcnt;
    logic [DIV_W-1:0] w_pcnt_d;
    logic             w_last;

    // div==0 never reaches terminal count, which freezes the timer
    assign w_last  = (i_div != '0) && (r_pcnt == (i_div - DIV_W'(1)));
    assign o_pulse = w_last;

    always_comb begin
        w_pcnt_d = r_pcnt + DIV_W'(1);
        if (i_clr || (i_div == '0) || w_last) begin
            w_pcnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= w_pcnt_d;
        end
    end

endmodule

// File: rtl/peri_timer.sv
// Memory-mapped timer: prescaled 32-bit counter with CPU-writable count and divider.
module peri_timer
    import peri_timer_pkg::*;
#(
    parameter int unsigned      CNT_W       = TIMER_CNT_W,
    parameter int unsigned      DIV_W       = TIMER_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(TIMER_DEFAULT_DIV)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_addr,
    input  logic             i_we,
    input  logic             i_wef,
    input  logic [31:0]      i_wdata,
    output logic [CNT_W-1:0] o_rdata,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_d;
    logic             r_tick;
    logic             w_tick_d;
    logic             w_pulse;
    logic             w_clr;

    // Address decode is done in the bridge; the address is intentionally ignored here
    logic w_unused_addr;
    assign w_unused_addr = ^i_addr;

    assign w_clr = i_we | i_wef;

    timer_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_div   (r_div),
        .i_clr   (w_clr),
        .o_pulse (w_pulse)
    );

    // A counter write wins over a coincident terminal count; a divider write discards it
    always_comb begin
        w_cnt_d = r_cnt;
        if (i_we) begin
            w_cnt_d = CNT_W'(i_wdata);
        end else if (w_pulse && !i_wef) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_div_d = r_div;
        if (i_wef) begin
            w_div_d = DIV_W'(i_wdata);
        end
    end

    assign w_tick_d = w_pulse & ~w_clr;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt  <= '0;
            r_div  <= DEFAULT_DIV;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_d;
            r_div  <= w_div_d;
            r_tick <= w_tick_d;
        end
    end

    assign o_rdata = r_cnt;
    assign o_tick  = r_tick;

endmodule

// File: tb/tb_peri_timer.sv
// Self-checking bench for peri_timer: directed scenarios plus randomized traffic vs a reference model.
module tb_peri_timer;

    localparam logic [31:0] DEF_DIV = 32'd4;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        we;
    logic        wef;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tick;

    int n_tests;
    int n_fail;

    // Reference model: counter value, divider, cycles elapsed in the current period, tick flag
    logic [31:0]     m_cnt;
    logic [31:0]     m_div;
    longint unsigned m_elapsed;
    logic            m_tick;

    peri_timer #(
        .CNT_W       (32),
        .DIV_W       (32),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_addr  (addr),
        .i_we    (we),
        .i_wef   (wef),
        .i_wdata (wdata),
        .o_rdata (rdata),
        .o_tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of the specification's rules, applied to the model at the rising edge
    task automatic model_edge(input bit r_n, input bit w, input bit wf, input logic [31:0] wd);
        bit period_done;
        period_done = (m_div != 0) && (m_elapsed + 1 == longint'(m_div));
        if (!r_n) begin
            m_cnt = 0; m_div = DEF_DIV; m_elapsed = 0; m_tick = 0;
        end else if (w || wf) begin
            if (w)  m_cnt = wd;
            if (wf) m_div = wd;
            m_elapsed = 0; m_tick = 0;
        end else if (m_div == 0) begin
            m_elapsed = 0; m_tick = 0;
        end else if (period_done) begin
            m_cnt = m_cnt + 1; m_elapsed = 0; m_tick = 1;
        end else begin
            m_elapsed++; m_tick = 0;
        end
    endtask

    task automatic step(input bit r_n, input bit w, input bit wf, input logic [31:0] wd);
        rst = r_n; we = w; wef = wf; wdata = wd;
        addr = w ? 32'h4000_0000 : (wf ? 32'h4000_0004 : $urandom);
        @(posedge clk);
        model_edge(r_n, w, wf, wd);
        #1;
        check("model_rdata", rdata, m_cnt);
        check("model_tick", {31'b0, tick}, {31'b0, m_tick});
        rst = 1'b1; we = 1'b0; wef = 1'b0;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, $urandom);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        m_cnt = 0; m_div = DEF_DIV; m_elapsed = 0; m_tick = 0;
        rst = 1'b0; we = 1'b0; wef = 1'b0; wdata = '0; addr = '0;

        // 1. Reset, then first tick DEF_DIV cycles after release
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_tick", {31'b0, tick}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check("first_tick_rdata", rdata, (i == 4) ? 32'h1 : 32'h0);
            check("first_tick_tick", {31'b0, tick}, (i == 4) ? 32'h1 : 32'h0);
        end

        // 2. Divider write of 3 from a clean reset
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'd3);
        for (int i = 1; i <= 9; i++) begin
            idle();
            check("div3_rdata", rdata, 32'(i / 3));
            check("div3_tick", {31'b0, tick}, (i % 3 == 0) ? 32'h1 : 32'h0);
        end

        // 3. Counter write on the terminal-count cycle beats the increment
        step(1'b1, 1'b0, 1'b1, 32'd2);
        idle();
        step(1'b1, 1'b1, 1'b0, 32'h100);
        check("wr_vs_tc_rdata", rdata, 32'h100);
        check("wr_vs_tc_tick", {31'b0, tick}, 32'h0);
        idle();
        check("wr_vs_tc_hold", rdata, 32'h100);
        idle();
        check("wr_vs_tc_next", rdata, 32'h101);
        check("wr_vs_tc_next_tick", {31'b0, tick}, 32'h1);

        // 4. Wrap at div=1
        step(1'b1, 1'b0, 1'b1, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        check("wrap_load", rdata, 32'hFFFF_FFFF);
        idle();
        check("wrap_zero", rdata, 32'h0);
        check("wrap_zero_tick", {31'b0, tick}, 32'h1);
        idle();
        check("wrap_one", rdata, 32'h1);
        check("wrap_one_tick", {31'b0, tick}, 32'h1);

        // 5. Freeze with div=0, then resume with div=5
        step(1'b1, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 100; i++) begin
            idle();
            check("freeze_rdata", rdata, 32'h1);
            check("freeze_tick", {31'b0, tick}, 32'h0);
        end
        step(1'b1, 1'b0, 1'b1, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            idle();
            check("resume_rdata", rdata, (i == 5) ? 32'h2 : 32'h1);
        end

        // 6. Reset coinciding with a counter write
        step(1'b1, 1'b0, 1'b1, 32'd2);
        step(1'b1, 1'b1, 1'b0, 32'h55);
        idle();
        step(1'b0, 1'b1, 1'b0, 32'h77);
        check("rst_vs_we_rdata", rdata, 32'h0);
        check("rst_vs_we_tick", {31'b0, tick}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check("rst_default_div", rdata, (i == 4) ? 32'h1 : 32'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            logic [31:0] d;
            r = $urandom_range(0, 255);
            if (r < 3) begin
                step(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            end else if (r < 15) begin
                d = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFFC + $urandom_range(0, 3));
                step(1'b1, 1'b1, r == 14, d);
            end else if (r < 23) begin
                step(1'b1, 1'b0, 1'b1, $urandom_range(0, 6));
            end else begin
                idle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
